// File: rtl/chunked_subtractor_pkg.sv
// chunked_subtractor_pkg: shared width, chunk default and FSM encodings for the chunked subtractor.
package chunked_subtractor_pkg;
   localparam int NBIT = 16;
   localparam int SUB_CHUNK = 4;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/chunked_subtractor_if.sv
// chunked_subtractor_if: start/done handshake and operand/result bus; ovf exists only with SUB_OVF_EN.
interface chunked_subtractor_if;
   import chunked_subtractor_pkg::*;
   logic start;
   logic [NBIT-1:0] a;
   logic [NBIT-1:0] b;
   logic ready;
   logic done;
   logic [NBIT-1:0] d;
   logic borrow;
`ifdef SUB_OVF_EN
   logic ovf;
`endif
   modport master (output start, a, b, input ready, done, d, borrow
`ifdef SUB_OVF_EN
      , ovf
`endif
   );
   modport slave (input start, a, b, output ready, done, d, borrow
`ifdef SUB_OVF_EN
      , ovf
`endif
   );
endinterface

// File: rtl/chunked_subtractor_sub_chunk.sv
// sub_chunk: combinational CHUNK-bit ripple-borrow subtractor, diff = x - y - bin.
module sub_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] x,
   input  logic [CHUNK-1:0] y,
   input  logic             bin,
   output logic [CHUNK-1:0] diff,
   output logic             bout
);
   logic [CHUNK:0] br;
   always_comb begin
      br = '0;
      diff = '0;
      br[0] = bin;
      for (int i = 0; i < CHUNK; i++) begin
         diff[i] = x[i] ^ y[i] ^ br[i];
         br[i+1] = (~x[i] & y[i]) | (~x[i] & br[i]) | (y[i] & br[i]);
      end
   end
   assign bout = br[CHUNK];
endmodule

// File: rtl/chunked_subtractor.sv
// chunked_subtractor: multi-cycle d = a - b, CHUNK bits per clock with a registered inter-chunk borrow.
// Optional signed-overflow output enabled by defining SUB_OVF_EN.
module chunked_subtractor
   import chunked_subtractor_pkg::*;
#(
   parameter int CHUNK = SUB_CHUNK
) (
   input logic clk,
   input logic rst,
   chunked_subtractor_if.slave bus
);
   localparam int K = NBIT / CHUNK;
   localparam int IW = (K > 1) ? $clog2(K) : 1;
   state_t state, state_nx;
   logic [NBIT-1:0] a_r, b_r, work, work_nx;
   logic [IW-1:0] idx;
   logic br, bout, last;
   logic [CHUNK-1:0] diff;
   assign last = idx == IW'(K - 1);
   assign bus.ready = state == IDLE;
   assign bus.done = state == DONE;
   sub_chunk #(.CHUNK(CHUNK)) u_sub (
      .x(a_r[idx*CHUNK +: CHUNK]),
      .y(b_r[idx*CHUNK +: CHUNK]),
      .bin(br),
      .diff(diff),
      .bout(bout)
   );
   always_comb begin
      work_nx = work;
      work_nx[idx*CHUNK +: CHUNK] = diff;
   end
   always_comb begin
      state_nx = state;
      state_nx = state == IDLE ? (bus.start ? RUN : IDLE)
               : state == RUN  ? (last ? DONE : RUN)
               : IDLE;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nx;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_r <= '0;
         b_r <= '0;
         work <= '0;
         br <= 1'b0;
         idx <= '0;
         bus.d <= '0;
         bus.borrow <= 1'b0;
`ifdef SUB_OVF_EN
         bus.ovf <= 1'b0;
`endif
      end else if (state == IDLE && bus.start) begin
         a_r <= bus.a;
         b_r <= bus.b;
         work <= '0;
         br <= 1'b0;
         idx <= '0;
      end else if (state == RUN) begin
         work <= work_nx;
         br <= bout;
         idx <= last ? '0 : idx + 1'b1;
         // Publish edge: the final chunk goes straight from the chain to d.
         if (last) begin
            bus.d <= work_nx;
            bus.borrow <= bout;
`ifdef SUB_OVF_EN
            bus.ovf <= (a_r[NBIT-1] != b_r[NBIT-1]) & (work_nx[NBIT-1] != a_r[NBIT-1]);
`endif
         end
      end
   end
endmodule

// File: tb/tb_chunked_subtractor.sv
// tb_chunked_subtractor: table-driven vectors plus handshake and mid-operation reset sequences.
module tb_chunked_subtractor;
   import chunked_subtractor_pkg::*;
   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] d;
      logic        borrow;
      logic        ovf;
   } vec_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_chk = 0;
   int n_fail = 0;
   chunked_subtractor_if bus ();
   chunked_subtractor dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic run_op(input logic [15:0] a, input logic [15:0] b, output int lat);
      int w;
      w = 0;
      @(negedge clk);
      while (!bus.ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      check("ready_before_start", {31'd0, bus.ready}, 32'd1);
      bus.a = a;
      bus.b = b;
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      lat = 0;
      while (lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (bus.done) break;
      end
   endtask

   vec_t vecs[7];
   logic [15:0] qa[$];
   logic [15:0] qb[$];
   logic [15:0] prev_d, ea, eb;
   int lat, done_cnt, last_done, c;

   initial begin
      vecs[0] = '{16'h1234, 16'h0034, 16'h1200, 1'b0, 1'b0};
      vecs[1] = '{16'h1000, 16'h0001, 16'h0FFF, 1'b0, 1'b0};
      vecs[2] = '{16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0};
      vecs[3] = '{16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1};
      vecs[4] = '{16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1};
      vecs[5] = '{16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0};
      vecs[6] = '{16'h00AB, 16'h1234, 16'hEE77, 1'b1, 1'b0};
      bus.start = 1'b0;
      bus.a = '0;
      bus.b = '0;
      #12;
      check("rst_ready", {31'd0, bus.ready}, 32'd1);
      check("rst_done", {31'd0, bus.done}, 32'd0);
      check("rst_d", {16'd0, bus.d}, 32'd0);
      check("rst_borrow", {31'd0, bus.borrow}, 32'd0);
`ifdef SUB_OVF_EN
      check("rst_ovf", {31'd0, bus.ovf}, 32'd0);
`endif
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 7; i++) begin
         run_op(vecs[i].a, vecs[i].b, lat);
         check($sformatf("vec%0d_latency", i), lat, 32'd4);
         check($sformatf("vec%0d_d", i), {16'd0, bus.d}, {16'd0, vecs[i].d});
         check($sformatf("vec%0d_borrow", i), {31'd0, bus.borrow}, {31'd0, vecs[i].borrow});
`ifdef SUB_OVF_EN
         check($sformatf("vec%0d_ovf", i), {31'd0, bus.ovf}, {31'd0, vecs[i].ovf});
`endif
         @(negedge clk);
         check($sformatf("vec%0d_done_pulse", i), {31'd0, bus.done}, 32'd0);
      end

      // start held high for 20 cycles with operands changing every cycle
      @(negedge clk);
      @(negedge clk);
      done_cnt = 0;
      last_done = -1;
      prev_d = bus.d;
      for (c = 0; c < 32; c++) begin
         if (c > 0) @(negedge clk);
         if (bus.done) begin
            done_cnt++;
            if (qa.size() > 0) begin
               ea = qa.pop_front();
               eb = qb.pop_front();
               check("hs_d", {16'd0, bus.d}, {16'd0, ea - eb});
               check("hs_borrow", {31'd0, bus.borrow}, {31'd0, ea < eb});
            end else check("hs_queue_nonempty", 32'd0, 32'd1);
            if (last_done >= 0) check("hs_done_period", c - last_done, 32'd6);
            last_done = c;
         end else check("hs_d_stable", {16'd0, bus.d}, {16'd0, prev_d});
         prev_d = bus.d;
         bus.start = c < 20;
         bus.a = 16'h0111 * 16'(c + 3);
         bus.b = 16'h0203 * 16'(c + 1);
         if (bus.ready && bus.start) begin
            qa.push_back(bus.a);
            qb.push_back(bus.b);
         end
      end
      check("hs_done_count", done_cnt, 32'd4);
      bus.start = 1'b0;

      // asynchronous reset during the second RUN cycle
      run_op(16'hABCD, 16'h0123, lat);
      check("pre_rst_d", {16'd0, bus.d}, 32'h0000AAAA);
      @(negedge clk);
      bus.a = 16'h0F0F;
      bus.b = 16'h1234;
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_ready", {31'd0, bus.ready}, 32'd1);
      check("mid_rst_done", {31'd0, bus.done}, 32'd0);
      check("mid_rst_d", {16'd0, bus.d}, 32'd0);
      check("mid_rst_borrow", {31'd0, bus.borrow}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      done_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.done) done_cnt++;
      end
      check("mid_rst_no_done", done_cnt, 32'd0);
      run_op(16'h0005, 16'h0003, lat);
      check("post_rst_latency", lat, 32'd4);
      check("post_rst_d", {16'd0, bus.d}, 32'h00000002);
      check("post_rst_borrow", {31'd0, bus.borrow}, 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
